decode_issue: RTL and testbench
===============================

# decode_issue

Decode-and-issue stage for the RV32I-subset pipeline: converts a fetched 32-bit instruction into the control bundle the execute ALU stage consumes (`aluop`, `funct`, `alusrc`, immediate, register indices, memory and writeback controls). It holds one decoded instruction in a registered output slot with valid/ready handshakes on both sides. A 32-entry pending-write scoreboard blocks RAW and WAW hazards against results still in flight, supporting in-order issue with out-of-order completion.

## Interface
- No parameters.
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: fetch presents an instruction.
- `in_instr` in 32: instruction word.
- `in_ready` out 1: stage accepts this cycle (combinational).
- `out_valid` out 1: decoded bundle valid.
- `out_ready` in 1: execute accepts the bundle.
- `out_aluop` out 2: 00 add, 01 sub, 10 use funct.
- `out_funct` out 10: `{funct7, funct3}`; funct7 in [9:3], funct3 in [2:0].
- `out_alusrc` out 1: 1 selects the immediate as ALU operand B.
- `out_imm` out 32: sign-extended immediate.
- `out_rs1`, `out_rs2`, `out_rd` out 5 each.
- `out_regwrite`, `out_memread`, `out_memwrite`, `out_branch`, `out_illegal` out 1 each.
- `wb_valid` in 1: a result is written back this cycle.
- `wb_rd` in 5: destination register being written back.
- `flush` in 1: discard the held bundle.

## Operation
- Decode table:
  - R-type (0110011): aluop 10, funct = `{instr[31:25], instr[14:12]}`, alusrc 0, regwrite 1; reads rs1 and rs2.
  - I-ALU (0010011): aluop 10, funct = `{7'b0, funct3}`, alusrc 1, regwrite 1, imm = sext(`instr[31:20]`); reads rs1.
  - LW (0000011): aluop 00, alusrc 1, memread 1, regwrite 1, I-immediate; reads rs1.
  - SW (0100011): aluop 00, alusrc 1, memwrite 1, imm = sext(`{instr[31:25], instr[11:7]}`); reads rs1 and rs2.
  - BEQ (1100011): aluop 01, alusrc 0, branch 1, imm = sext(`{instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}`); reads rs1 and rs2.
  - Any other opcode: illegal 1, and all of regwrite, memread, memwrite and branch are 0. An illegal instruction still issues.
- Register indices are always copied from their fixed fields. `rd` is forced to 0 when regwrite is 0.
- Scoreboard: `pending[31:1]`. Register x0 is never pending.
  - Set `pending[rd]` on issue, i.e. when `out_valid & out_ready & out_regwrite`.
  - Clear `pending[wb_rd]` when `wb_valid`.
  - If set and clear hit the same index in the same cycle, set wins.
- Hazard: any source the instruction reads, or its rd if it writes, is nonzero and either:
  - is pending, or
  - equals `out_rd` of a held bundle with `out_valid & out_regwrite`.
- `in_ready = (!out_valid | out_ready) & !hazard & !flush`.
- Output register:
  - On accept (`in_valid & in_ready`), load the decoded bundle and set `out_valid`.
  - Else, if `out_ready` or `flush`, clear `out_valid`.
- Flush drops only the held bundle. No scoreboard bit is set by a flushed bundle. The scoreboard is otherwise untouched.

## Timing
- Latency is 1 cycle from accept to `out_valid`. Full throughput is one instruction per cycle when there are no hazards.
- Output fields are stable while `out_valid & !out_ready`.
- Reset values: `out_valid` 0, every out_* field 0, scoreboard all 0. Reset overrides flush, writeback and accept in the same cycle.
- Default build: a writeback clear becomes visible to the hazard check on the next cycle. A dependent instruction is accepted at the earliest 1 cycle after its `wb_valid`.
- Simultaneous accept of a new instruction and issue of the held bundle is permitted. The new instruction's hazard check includes the departing bundle's rd through the held-bundle comparison.

## Configuration
- `DECODE_ISSUE_WB_BYPASS_EN`:
  - Defined: the hazard check uses `pending & ~(wb_valid ? onehot(wb_rd) : 0)`. A dependent instruction is accepted in the same cycle as its writeback.
  - Undefined: no bypass; timing as above.

## Test plan
- **add decode:** reset, then `0x002081B3` (add x3,x1,x2) with `out_ready`=1 → the next cycle shows `out_valid` 1, aluop 10, funct `0x000`, rs1 1, rs2 2, rd 3, regwrite 1, alusrc 0.
- **Immediate decode:**
  - `0xFFF00293` (addi x5,x0,-1) → imm `0xFFFFFFFF`, alusrc 1, funct `0x000`.
  - `0xFE208CE3` (beq x1,x2,-8) → imm `0xFFFFFFF8`, aluop 01, branch 1, rd 0.
- **RAW stall:** issue `0x0082A303` (lw x6,8(x5)), then present `0x00602223` (sw x6,4(x0)) → `in_ready` 0 until 1 cycle after `wb_valid`=1 with `wb_rd`=6. With the bypass macro, it is accepted in the writeback cycle.
- **Back-pressure:** hold `out_ready`=0 for 3 cycles with a valid bundle → fields stay constant and `in_ready` stays 0. On release, the bundle issues and the next instruction is accepted the same cycle.
- **Flush:** flush while a bundle with rd 3 is held → `out_valid` 0 next cycle and `pending[3]` stays 0. A following instruction reading x3 is accepted immediately.
- **Illegal opcode and reset:** `0x0000007F` → `out_illegal` 1 with regwrite, memread, memwrite and branch all 0. Asserting `reset` mid-stall → `out_valid` 0 and scoreboard cleared next cycle.

Source files
------------

// File: rtl/decode_issue.sv
// decode_issue: RV32I-subset decode/issue stage with one registered output
// slot, valid/ready handshakes on both sides and a pending-write scoreboard.
// Ports:
//   clk, reset (sync, active-high)
//   in_valid/in_instr/in_ready          fetch side
//   out_valid/out_ready + out_* fields  execute side
//   wb_valid/wb_rd                      writeback clears scoreboard bits
//   flush                               drops the held bundle
// Option: DECODE_ISSUE_WB_BYPASS_EN lets a same-cycle writeback clear
// the hazard immediately.
module decode_issue (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_instr,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  out_aluop,
    output logic [9:0]  out_funct,
    output logic        out_alusrc,
    output logic [31:0] out_imm,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic [4:0]  out_rd,
    output logic        out_regwrite,
    output logic        out_memread,
    output logic        out_memwrite,
    output logic        out_branch,
    output logic        out_illegal,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic        flush
);

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    logic [6:0]  opcode;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;

    logic [1:0]  d_aluop;
    logic [9:0]  d_funct;
    logic        d_alusrc;
    logic [31:0] d_imm;
    logic        d_regwrite;
    logic        d_memread;
    logic        d_memwrite;
    logic        d_branch;
    logic        d_illegal;
    logic        d_use_rs1;
    logic        d_use_rs2;
    logic [4:0]  d_rs1;
    logic [4:0]  d_rs2;
    logic [4:0]  d_rd;

    logic [31:0] pending;
    logic [31:0] pending_nxt;
    logic [31:0] busy;
    logic        held_wr;
    logic        hazard;
    logic        accept;
    logic        issue;

    assign opcode = in_instr[6:0];

    assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s = {{20{in_instr[31]}}, in_instr[31:25],
                    in_instr[11:7]};
    assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                    in_instr[30:25], in_instr[11:8], 1'b0};

    always_comb begin
        d_aluop    = 2'b00;
        d_funct    = 10'd0;
        d_alusrc   = 1'b0;
        d_imm      = 32'd0;
        d_regwrite = 1'b0;
        d_memread  = 1'b0;
        d_memwrite = 1'b0;
        d_branch   = 1'b0;
        d_illegal  = 1'b0;
        d_use_rs1  = 1'b0;
        d_use_rs2  = 1'b0;
        unique case (opcode)
            OP_R: begin
                d_aluop    = 2'b10;
                d_funct    = {in_instr[31:25], in_instr[14:12]};
                d_regwrite = 1'b1;
                d_use_rs1  = 1'b1;
                d_use_rs2  = 1'b1;
            end
            OP_I: begin
                d_aluop    = 2'b10;
                d_funct    = {7'd0, in_instr[14:12]};
                d_alusrc   = 1'b1;
                d_imm      = imm_i;
                d_regwrite = 1'b1;
                d_use_rs1  = 1'b1;
            end
            OP_LW: begin
                d_alusrc   = 1'b1;
                d_imm      = imm_i;
                d_memread  = 1'b1;
                d_regwrite = 1'b1;
                d_use_rs1  = 1'b1;
            end
            OP_SW: begin
                d_alusrc   = 1'b1;
                d_imm      = imm_s;
                d_memwrite = 1'b1;
                d_use_rs1  = 1'b1;
                d_use_rs2  = 1'b1;
            end
            OP_BEQ: begin
                d_aluop    = 2'b01;
                d_imm      = imm_b;
                d_branch   = 1'b1;
                d_use_rs1  = 1'b1;
                d_use_rs2  = 1'b1;
            end
            default: begin
                d_illegal  = 1'b1;
            end
        endcase
    end

    assign d_rs1 = in_instr[19:15];
    assign d_rs2 = in_instr[24:20];
    assign d_rd  = d_regwrite ? in_instr[11:7] : 5'd0;

`ifdef DECODE_ISSUE_WB_BYPASS_EN
    logic [31:0] wb_mask;
    assign wb_mask = wb_valid ? (32'd1 << wb_rd) : 32'd0;
    assign busy    = pending & ~wb_mask;
`else
    assign busy = pending;
`endif

    // The held bundle's rd is not yet in the scoreboard (it is set on
    // issue), so it is compared separately.
    assign held_wr = out_valid & out_regwrite;

    function automatic logic blocked(
        input logic [4:0]  r,
        input logic [31:0] b,
        input logic        hv,
        input logic [4:0]  hrd
    );
        return (r != 5'd0) && (b[r] || (hv && (r == hrd)));
    endfunction

    assign hazard =
        (d_use_rs1  & blocked(d_rs1, busy, held_wr, out_rd)) |
        (d_use_rs2  & blocked(d_rs2, busy, held_wr, out_rd)) |
        (d_regwrite & blocked(d_rd,  busy, held_wr, out_rd));

    assign in_ready = (~out_valid | out_ready) & ~hazard & ~flush;
    assign accept   = in_valid & in_ready;

    // A flushed bundle never reaches execute, so it must not mark rd.
    assign issue = out_valid & out_ready & out_regwrite & ~flush;

    always_comb begin
        pending_nxt = pending;
        if (wb_valid) begin
            pending_nxt[wb_rd] = 1'b0;
        end
        if (issue) begin
            pending_nxt[out_rd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending      <= 32'd0;
            out_valid    <= 1'b0;
            out_aluop    <= 2'b00;
            out_funct    <= 10'd0;
            out_alusrc   <= 1'b0;
            out_imm      <= 32'd0;
            out_rs1      <= 5'd0;
            out_rs2      <= 5'd0;
            out_rd       <= 5'd0;
            out_regwrite <= 1'b0;
            out_memread  <= 1'b0;
            out_memwrite <= 1'b0;
            out_branch   <= 1'b0;
            out_illegal  <= 1'b0;
        end else begin
            pending <= pending_nxt;
            if (accept) begin
                out_valid    <= 1'b1;
                out_aluop    <= d_aluop;
                out_funct    <= d_funct;
                out_alusrc   <= d_alusrc;
                out_imm      <= d_imm;
                out_rs1      <= d_rs1;
                out_rs2      <= d_rs2;
                out_rd       <= d_rd;
                out_regwrite <= d_regwrite;
                out_memread  <= d_memread;
                out_memwrite <= d_memwrite;
                out_branch   <= d_branch;
                out_illegal  <= d_illegal;
            end else if (out_ready | flush) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_decode_issue.sv
// tb_decode_issue: directed scenarios plus randomized traffic checked
// against a behavioural decode/scoreboard model.
module tb_decode_issue;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_aluop;
    logic [9:0]  out_funct;
    logic        out_alusrc;
    logic [31:0] out_imm;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic        out_regwrite;
    logic        out_memread;
    logic        out_memwrite;
    logic        out_branch;
    logic        out_illegal;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;

    always #5 clk = ~clk;

    decode_issue dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_instr     (in_instr),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_aluop    (out_aluop),
        .out_funct    (out_funct),
        .out_alusrc   (out_alusrc),
        .out_imm      (out_imm),
        .out_rs1      (out_rs1),
        .out_rs2      (out_rs2),
        .out_rd       (out_rd),
        .out_regwrite (out_regwrite),
        .out_memread  (out_memread),
        .out_memwrite (out_memwrite),
        .out_branch   (out_branch),
        .out_illegal  (out_illegal),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .flush        (flush)
    );

    localparam logic [31:0] ADD   = 32'h002081B3;
    localparam logic [31:0] ADDI  = 32'hFFF00293;
    localparam logic [31:0] BEQ   = 32'hFE208CE3;
    localparam logic [31:0] LW    = 32'h0082A303;
    localparam logic [31:0] SW    = 32'h00602223;
    localparam logic [31:0] ILL   = 32'h0000007F;
    localparam logic [31:0] ADDI7 = 32'h00100393;
    localparam logic [31:0] ADDX3 = 32'h00018233;

    int checks = 0;
    int errors = 0;

    task automatic chk(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [1:0]  aluop;
        logic [9:0]  funct;
        logic        alusrc;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        br;
        logic        ill;
        logic        use1;
        logic        use2;
        logic        c_alu;
        logic        c_funct;
        logic        c_imm;
    } dec_t;

    // Model state: set of registers with results in flight, plus the
    // bundle the stage should currently be holding.
    bit   pend [32];
    bit   m_valid;
    dec_t m;

    function automatic dec_t decode_ref(input logic [31:0] ins);
        dec_t d;
        int   off;
        d = '0;
        d.rs1   = ins[19:15];
        d.rs2   = ins[24:20];
        d.c_alu = 1'b1;
        case (ins[6:0])
            7'h33: begin
                d.aluop   = 2'd2;
                d.funct   = {ins[31:25], ins[14:12]};
                d.rw      = 1'b1;
                d.use1    = 1'b1;
                d.use2    = 1'b1;
                d.c_funct = 1'b1;
            end
            7'h13: begin
                d.aluop   = 2'd2;
                d.funct   = 10'(ins[14:12]);
                d.alusrc  = 1'b1;
                d.imm     = 32'($signed(ins) >>> 20);
                d.rw      = 1'b1;
                d.use1    = 1'b1;
                d.c_funct = 1'b1;
                d.c_imm   = 1'b1;
            end
            7'h03: begin
                d.alusrc = 1'b1;
                d.imm    = 32'($signed(ins) >>> 20);
                d.mr     = 1'b1;
                d.rw     = 1'b1;
                d.use1   = 1'b1;
                d.c_imm  = 1'b1;
            end
            7'h23: begin
                off = (ins[31] ? -2048 : 0) + int'(ins[30:25]) * 32
                    + int'(ins[11:7]);
                d.alusrc = 1'b1;
                d.imm    = 32'(off);
                d.mw     = 1'b1;
                d.use1   = 1'b1;
                d.use2   = 1'b1;
                d.c_imm  = 1'b1;
            end
            7'h63: begin
                off = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048
                    + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
                d.aluop = 2'd1;
                d.imm   = 32'(off);
                d.br    = 1'b1;
                d.use1  = 1'b1;
                d.use2  = 1'b1;
                d.c_imm = 1'b1;
            end
            default: begin
                d.ill   = 1'b1;
                d.c_alu = 1'b0;
            end
        endcase
        d.rd = d.rw ? ins[11:7] : 5'd0;
        return d;
    endfunction

    function automatic bit busy_ref(input logic [4:0] r);
        bit p;
        p = pend[r];
`ifdef DECODE_ISSUE_WB_BYPASS_EN
        if (wb_valid && wb_rd == r) p = 1'b0;
`endif
        return (r != 5'd0) && (p || (m_valid && m.rw && m.rd == r));
    endfunction

    function automatic bit ready_ref();
        dec_t d;
        bit   hz;
        d  = decode_ref(in_instr);
        hz = (d.use1 && busy_ref(d.rs1)) ||
             (d.use2 && busy_ref(d.rs2)) ||
             (d.rw && busy_ref(d.rd));
        return (!m_valid || out_ready) && !flush && !hz;
    endfunction

    task automatic check_out();
        chk("out_valid", out_valid, m_valid);
        if (m_valid) begin
            chk("rs1", out_rs1, m.rs1);
            chk("rs2", out_rs2, m.rs2);
            chk("rd", out_rd, m.rd);
            chk("ctl", {out_regwrite, out_memread, out_memwrite,
                        out_branch, out_illegal},
                       {m.rw, m.mr, m.mw, m.br, m.ill});
            if (m.c_alu) begin
                chk("aluop", out_aluop, m.aluop);
                chk("alusrc", out_alusrc, m.alusrc);
            end
            if (m.c_funct) chk("funct", out_funct, m.funct);
            if (m.c_imm) chk("imm", out_imm, m.imm);
        end
    endtask

    task automatic step(
        input  logic        iv,
        input  logic [31:0] ins,
        input  logic        ordy,
        input  logic        wv,
        input  logic [4:0]  wr,
        input  logic        fl,
        output logic        rdy
    );
        bit er;
        bit iss;
        in_valid  = iv;
        in_instr  = ins;
        out_ready = ordy;
        wb_valid  = wv;
        wb_rd     = wr;
        flush     = fl;
        #1;
        er  = ready_ref();
        rdy = in_ready;
        chk("in_ready", in_ready, er);
        iss = m_valid && ordy && m.rw && !fl;
        if (wv) pend[wr] = 1'b0;
        if (iss) pend[m.rd] = 1'b1;
        pend[0] = 1'b0;
        if (iv && er) begin
            m       = decode_ref(ins);
            m_valid = 1'b1;
        end else if (ordy || fl) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic do_reset(
        input logic        iv,
        input logic [31:0] ins,
        input logic        ordy,
        input logic        wv,
        input logic [4:0]  wr
    );
        reset     = 1'b1;
        in_valid  = iv;
        in_instr  = ins;
        out_ready = ordy;
        wb_valid  = wv;
        wb_rd     = wr;
        flush     = 1'b0;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        m_valid = 1'b0;
        m       = '0;
        foreach (pend[i]) pend[i] = 1'b0;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_imm", out_imm, 32'd0);
        chk("rst_fields", {out_aluop, out_funct, out_rs1, out_rs2,
                           out_rd}, 32'd0);
        chk("rst_ctl", {out_alusrc, out_regwrite, out_memread,
                        out_memwrite, out_branch, out_illegal}, 32'd0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w        = $urandom;
        w[11:7]  = 5'($urandom_range(0, 7));
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        case ($urandom_range(0, 5))
            0: w[6:0] = 7'h33;
            1: w[6:0] = 7'h13;
            2: w[6:0] = 7'h03;
            3: w[6:0] = 7'h23;
            4: w[6:0] = 7'h63;
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        logic       r;
        logic       wv;
        logic [4:0] wr;
        int         q[$];

        do_reset(1'b0, 32'd0, 1'b0, 1'b0, 5'd0);

        // add / immediate / branch / illegal decode
        step(1, ADD, 1, 0, 0, 0, r);
        chk("add_acc", r, 1'b1);
        chk("add_valid", out_valid, 1'b1);
        chk("add_aluop", out_aluop, 2'b10);
        chk("add_funct", out_funct, 10'h000);
        chk("add_regs", {out_rs1, out_rs2, out_rd}, {5'd1, 5'd2, 5'd3});
        chk("add_rw_src", {out_regwrite, out_alusrc}, 2'b10);
        step(1, ADDI, 1, 0, 0, 0, r);
        chk("addi_acc", r, 1'b1);
        chk("addi_imm", out_imm, 32'hFFFFFFFF);
        chk("addi_src", out_alusrc, 1'b1);
        chk("addi_funct", out_funct, 10'h000);
        step(1, BEQ, 1, 0, 0, 0, r);
        chk("beq_imm", out_imm, 32'hFFFFFFF8);
        chk("beq_aluop", out_aluop, 2'b01);
        chk("beq_branch", out_branch, 1'b1);
        chk("beq_rd", out_rd, 5'd0);
        step(1, ILL, 1, 0, 0, 0, r);
        chk("ill_flag", out_illegal, 1'b1);
        chk("ill_ctl", {out_regwrite, out_memread, out_memwrite,
                        out_branch}, 4'b0000);
        step(0, 32'd0, 1, 0, 0, 0, r);

        // RAW stall on lw -> sw
        do_reset(0, 32'd0, 0, 0, 5'd0);
        step(1, LW, 1, 0, 0, 0, r);
        chk("lw_acc", r, 1'b1);
        step(1, SW, 1, 0, 0, 0, r);
        chk("raw_held", r, 1'b0);
        step(1, SW, 1, 0, 0, 0, r);
        chk("raw_pend", r, 1'b0);
        step(1, SW, 1, 1, 5'd6, 0, r);
`ifdef DECODE_ISSUE_WB_BYPASS_EN
        chk("raw_bypass", r, 1'b1);
`else
        chk("raw_wb_cycle", r, 1'b0);
        step(1, SW, 1, 0, 0, 0, r);
        chk("raw_release", r, 1'b1);
`endif

        // reset in the middle of a stall
        do_reset(0, 32'd0, 0, 0, 5'd0);
        step(1, LW, 1, 0, 0, 0, r);
        step(1, SW, 1, 0, 0, 0, r);
        step(1, SW, 0, 0, 0, 0, r);
        do_reset(1, SW, 1, 1, 5'd9);
        step(1, SW, 1, 0, 0, 0, r);
        chk("rst_sb_clear", r, 1'b1);

        // back-pressure
        do_reset(0, 32'd0, 0, 0, 5'd0);
        step(1, ADD, 0, 0, 0, 0, r);
        for (int i = 0; i < 3; i++) begin
            step(1, ADDI7, 0, 0, 0, 0, r);
            chk("bp_stall", r, 1'b0);
            chk("bp_hold", {out_valid, out_rd, out_rs1},
                           {1'b1, 5'd3, 5'd1});
        end
        step(1, ADDI7, 1, 0, 0, 0, r);
        chk("bp_release", r, 1'b1);
        chk("bp_next", {out_valid, out_rd, out_imm[7:0]},
                       {1'b1, 5'd7, 8'd1});

        // flush of a held rd=3 bundle
        do_reset(0, 32'd0, 0, 0, 5'd0);
        step(1, ADD, 1, 0, 0, 0, r);
        step(0, 32'd0, 0, 0, 0, 1, r);
        chk("flush_rdy", r, 1'b0);
        chk("flush_valid", out_valid, 1'b0);
        step(1, ADDX3, 1, 0, 0, 0, r);
        chk("flush_no_pend", r, 1'b1);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            q.delete();
            for (int i = 1; i < 32; i++) if (pend[i]) q.push_back(i);
            wv = ($urandom_range(0, 99) < 35);
            if (q.size() > 0 && $urandom_range(0, 3) != 0)
                wr = 5'(q[$urandom_range(0, q.size() - 1)]);
            else
                wr = 5'($urandom_range(0, 7));
            step(($urandom_range(0, 99) < 80), rand_instr(),
                 ($urandom_range(0, 99) < 70), wv, wr,
                 ($urandom_range(0, 99) < 5), r);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
